// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - safety monitor between light controller and lamp drivers (option: TRAFFIC_MONITOR_FAULT_COUNT_EN)
module traffic_light_monitor #(
    parameter int STARTUP_CYCLES = 16,
    parameter int FLASH_HALF     = 8,
    parameter int MAX_HOLD       = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1_in,
    input  logic [2:0] light_M2_in,
    input  logic [2:0] light_MT_in,
    input  logic [2:0] light_S_in,
    input  logic       fault_clr,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic       fault,
    output logic [2:0] fault_code
`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    typedef enum logic [1:0] {STARTUP, PASS, FAULT_FLASH} state_t;

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    localparam logic [2:0] CODE_INVALID  = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_SKIP     = 3'd3;
    localparam logic [2:0] CODE_WATCHDOG = 3'd4;

    localparam int SW = $clog2(STARTUP_CYCLES + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam int WW = $clog2(MAX_HOLD + 1);

    localparam logic [SW-1:0] SU_LAST = SW'(STARTUP_CYCLES - 1);
    localparam logic [FW-1:0] BC_LAST = FW'(FLASH_HALF - 1);
    localparam logic [WW-1:0] WD_LAST = WW'(MAX_HOLD - 1);

    state_t        state, state_next;
    logic [2:0]    r_m1, r_m2, r_mt, r_s;
    logic [2:0]    p_m1, p_m2, p_mt, p_s;
    logic [SW-1:0] su_cnt, su_next;
    logic [FW-1:0] bc, bc_next;
    logic          phase, phase_next;
    logic [WW-1:0] wd_cnt, wd_next;
    logic [2:0]    m1_next, m2_next, mt_next, s_next;
    logic          fault_next;
    logic [2:0]    code_next;
    logic          conflict, invalid, skipped, changed, wd_hit;
    logic [2:0]    cause;
    logic          enter;
    logic [2:0]    enter_code;

    function automatic logic is_go(input logic [2:0] v);
        return v[1] | v[0];
    endfunction

    // Stage 1: capture controller outputs and keep the previous capture for transition checks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m1 <= RED;
            r_m2 <= RED;
            r_mt <= RED;
            r_s  <= RED;
            p_m1 <= RED;
            p_m2 <= RED;
            p_mt <= RED;
            p_s  <= RED;
        end else begin
            r_m1 <= light_M1_in;
            r_m2 <= light_M2_in;
            r_mt <= light_MT_in;
            r_s  <= light_S_in;
            p_m1 <= r_m1;
            p_m2 <= r_m2;
            p_mt <= r_mt;
            p_s  <= r_s;
        end
    end

    // Fault checks on the stage-1 pattern, resolved to a single prioritised cause
    always_comb begin
        conflict = (is_go(r_s) && (is_go(r_m1) || is_go(r_m2) || is_go(r_mt)))
                 || (is_go(r_mt) && is_go(r_m2));
        invalid  = !($onehot(r_m1) && $onehot(r_m2) && $onehot(r_mt) && $onehot(r_s));
        skipped  = (p_m1 == GRN && r_m1 == RED) || (p_m2 == GRN && r_m2 == RED)
                 || (p_mt == GRN && r_mt == RED) || (p_s == GRN && r_s == RED);
        changed  = {r_m1, r_m2, r_mt, r_s} != {p_m1, p_m2, p_mt, p_s};
        wd_hit   = (wd_cnt == WD_LAST);
        cause    = 3'd0;
        if (conflict)     cause = CODE_CONFLICT;
        else if (invalid) cause = CODE_INVALID;
        else if (skipped) cause = CODE_SKIP;
        else if (wd_hit)  cause = CODE_WATCHDOG;
    end

    // Next state, counters and the stage-2 lamp pattern
    always_comb begin
        state_next = state;
        su_next    = su_cnt;
        bc_next    = bc;
        phase_next = phase;
        wd_next    = '0;
        m1_next    = RED;
        m2_next    = RED;
        mt_next    = RED;
        s_next     = RED;
        fault_next = fault;
        code_next  = fault_code;
        enter      = 1'b0;
        enter_code = 3'd0;
        case (state)
            STARTUP: begin
                if (conflict) begin
                    enter      = 1'b1;
                    enter_code = CODE_CONFLICT;
                end else if (su_cnt == SU_LAST) begin
                    state_next = PASS;
                    su_next    = '0;
                end else begin
                    su_next = su_cnt + 1'b1;
                end
            end
            PASS: begin
                m1_next = r_m1;
                m2_next = r_m2;
                mt_next = r_mt;
                s_next  = r_s;
                if (cause != 3'd0) begin
                    enter      = 1'b1;
                    enter_code = cause;
                end else begin
                    wd_next = changed ? '0 : wd_cnt + 1'b1;
                end
            end
            FAULT_FLASH: begin
                if (fault_clr && !conflict && !invalid) begin
                    state_next = STARTUP;
                    su_next    = '0;
                    fault_next = 1'b0;
                    code_next  = 3'd0;
                end else begin
                    if (bc == BC_LAST) begin
                        bc_next    = '0;
                        phase_next = !phase;
                    end else begin
                        bc_next = bc + 1'b1;
                    end
                    if (phase_next) begin
                        m1_next = YEL;
                        m2_next = YEL;
                        mt_next = YEL;
                        s_next  = RED;
                    end else begin
                        m1_next = DARK;
                        m2_next = DARK;
                        mt_next = DARK;
                        s_next  = DARK;
                    end
                end
            end
            default: state_next = STARTUP;
        endcase
        // the faulting pattern is replaced by the first ON half of the blink
        if (enter) begin
            state_next = FAULT_FLASH;
            su_next    = '0;
            fault_next = 1'b1;
            code_next  = enter_code;
            phase_next = 1'b1;
            bc_next    = '0;
            m1_next    = YEL;
            m2_next    = YEL;
            mt_next    = YEL;
            s_next     = RED;
        end
    end

    // State register and stage-2 output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= STARTUP;
            su_cnt     <= '0;
            bc         <= '0;
            phase      <= 1'b0;
            wd_cnt     <= '0;
            light_M1   <= RED;
            light_M2   <= RED;
            light_MT   <= RED;
            light_S    <= RED;
            fault      <= 1'b0;
            fault_code <= 3'd0;
        end else begin
            state      <= state_next;
            su_cnt     <= su_next;
            bc         <= bc_next;
            phase      <= phase_next;
            wd_cnt     <= wd_next;
            light_M1   <= m1_next;
            light_M2   <= m2_next;
            light_MT   <= mt_next;
            light_S    <= s_next;
            fault      <= fault_next;
            fault_code <= code_next;
        end
    end

`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
    // Saturating count of fault entries; only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_count <= 8'd0;
        end else if (enter && fault_count != 8'hFF) begin
            fault_count <= fault_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - self-checking bench for traffic_light_monitor
module tb_traffic_light_monitor;

    localparam int SC = 16;
    localparam int FH = 8;
    localparam int MH = 32;

    localparam int M_START = 0;
    localparam int M_PASS  = 1;
    localparam int M_FLASH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_m1, in_m2, in_mt, in_s;
    logic       fault_clr;
    logic [2:0] light_m1, light_m2, light_mt, light_s;
    logic       fault;
    logic [2:0] fault_code;
`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif

    int checks;
    int errors;

    // reference model: lanes packed as [0]=M1 [1]=M2 [2]=MT [3]=S
    logic [3:0][2:0] mr, mp, eo;
    logic            ef;
    logic [2:0]      ecode;
    int              mode, since, hold, ecount;
    int              ph_idx;
    logic [11:0]     v;

    traffic_light_monitor #(
        .STARTUP_CYCLES(SC),
        .FLASH_HALF    (FH),
        .MAX_HOLD      (MH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1_in(in_m1),
        .light_M2_in(in_m2),
        .light_MT_in(in_mt),
        .light_S_in (in_s),
        .fault_clr  (fault_clr),
        .light_M1   (light_m1),
        .light_M2   (light_m2),
        .light_MT   (light_mt),
        .light_S    (light_s),
        .fault      (fault),
`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
        .fault_count(fault_count),
`endif
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    // legal controller phases, {S,MT,M2,M1}; consecutive phases never skip yellow
    function automatic logic [11:0] phase_val(input int i);
        case (i)
            0:       return {3'b100, 3'b100, 3'b001, 3'b001};
            1:       return {3'b100, 3'b100, 3'b010, 3'b001};
            2:       return {3'b100, 3'b001, 3'b100, 3'b001};
            3:       return {3'b100, 3'b010, 3'b100, 3'b010};
            4:       return {3'b001, 3'b100, 3'b100, 3'b100};
            default: return {3'b010, 3'b100, 3'b100, 3'b100};
        endcase
    endfunction

    function automatic logic [2:0] bad_code(input int i);
        case (i)
            0:       return 3'b000;
            1:       return 3'b011;
            2:       return 3'b101;
            3:       return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    function automatic bit lane_go(input logic [2:0] x);
        return (x == 3'b001) || (x == 3'b010) || (x == 3'b011) || (x == 3'b101) || (x == 3'b110) || (x == 3'b111);
    endfunction

    function automatic bit legal(input logic [2:0] x);
        return (x == 3'b001) || (x == 3'b010) || (x == 3'b100);
    endfunction

    task automatic set_lights(input logic [11:0] val);
        {in_s, in_mt, in_m2, in_m1} = val;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("light_M1", light_m1, eo[0]);
        check("light_M2", light_m2, eo[1]);
        check("light_MT", light_mt, eo[2]);
        check("light_S", light_s, eo[3]);
        check("fault", fault, ef);
        check("fault_code", fault_code, ecode);
`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
        check("fault_count", fault_count, 8'(ecount));
`endif
    endtask

    function automatic void model_reset();
        mode   = M_START;
        since  = 0;
        hold   = 0;
        ecount = 0;
        mr     = {4{3'b100}};
        mp     = {4{3'b100}};
        eo     = {4{3'b100}};
        ef     = 1'b0;
        ecode  = 3'd0;
    endfunction

    function automatic void model_enter(input int c);
        mode  = M_FLASH;
        since = 0;
        hold  = 0;
        ef    = 1'b1;
        ecode = 3'(c);
        eo    = {3'b100, 3'b010, 3'b010, 3'b010};
        if (ecount < 255) ecount++;
    endfunction

    // one clock of the rules, evaluated on the values present before the edge
    function automatic void model_step();
        bit cf, inv, sk;
        int cause;
        cf  = (lane_go(mr[3]) && (lane_go(mr[0]) || lane_go(mr[1]) || lane_go(mr[2])))
            || (lane_go(mr[2]) && lane_go(mr[1]));
        inv = 1'b0;
        sk  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!legal(mr[i])) inv = 1'b1;
            if (mp[i] == 3'b001 && mr[i] == 3'b100) sk = 1'b1;
        end
        case (mode)
            M_START: begin
                if (cf) model_enter(2);
                else begin
                    eo = {4{3'b100}};
                    if (since == SC - 1) begin
                        mode = M_PASS;
                        hold = 0;
                    end else since++;
                end
            end
            M_PASS: begin
                cause = cf ? 2 : inv ? 1 : sk ? 3 : (hold == MH - 1) ? 4 : 0;
                if (cause != 0) model_enter(cause);
                else begin
                    eo   = mr;
                    hold = (mr == mp) ? hold + 1 : 0;
                end
            end
            default: begin
                if (fault_clr && !cf && !inv) begin
                    mode  = M_START;
                    since = 0;
                    ef    = 1'b0;
                    ecode = 3'd0;
                    eo    = {4{3'b100}};
                end else begin
                    since++;
                    if (((since / FH) % 2) == 0) eo = {3'b100, 3'b010, 3'b010, 3'b010};
                    else eo = {4{3'b000}};
                end
            end
        endcase
        mp = mr;
        mr = {in_s, in_mt, in_m2, in_m1};
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst = 1'b1;
    endtask

    task automatic run_phases(input int n);
        for (int k = 0; k < n; k++) begin
            ph_idx = (ph_idx + 1) % 6;
            set_lights(phase_val(ph_idx));
            repeat ($urandom_range(1, 6)) cycle();
        end
    endtask

    task automatic force_conflict();
        in_m1 = 3'b001;
        in_s  = 3'b001;
        cycle();
        cycle();
        check("conflict_fault", fault, 1'b1);
        check("conflict_code", fault_code, 3'd2);
    endtask

    task automatic do_clear();
        ph_idx = 0;
        set_lights(phase_val(0));
        repeat (2) cycle();
        fault_clr = 1'b1;
        cycle();
        fault_clr = 1'b0;
        check("clr_fault", fault, 1'b0);
        check("clr_code", fault_code, 3'd0);
        repeat (SC) cycle();
        run_phases(8);
    endtask

    task automatic hold_trial(input int len);
        ph_idx = (ph_idx + 1) % 6;
        set_lights(phase_val(ph_idx));
        repeat (len) cycle();
        ph_idx = (ph_idx + 1) % 6;
        set_lights(phase_val(ph_idx));
        cycle();
        cycle();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        fault_clr = 1'b0;
        ph_idx    = 0;
        set_lights(phase_val(0));
        model_reset();
        #2;
        do_reset();

        // clean start-up then pass-through
        repeat (SC + 2) cycle();
        run_phases(12);
        check("clean_fault", fault, 1'b0);

        // conflict, full blink period, clear refused while still conflicting
        force_conflict();
        repeat (18) cycle();
        fault_clr = 1'b1;
        cycle();
        fault_clr = 1'b0;
        cycle();
        check("clr_refused", fault, 1'b1);
        do_clear();

        // invalid encoding on the turn lane
        v = phase_val(2);
        v[8:6] = bad_code($urandom_range(0, 4));
        set_lights(v);
        cycle();
        cycle();
        check("invalid_code", fault_code, 3'd1);
        repeat (4) cycle();
        do_clear();

        // skipped yellow after a fresh reset, then asynchronous reset mid-flash
        do_reset();
        ph_idx = 0;
        set_lights(phase_val(0));
        repeat (SC + 4) cycle();
        in_m1 = 3'b100;
        cycle();
        cycle();
        check("skip_code", fault_code, 3'd3);
        repeat (5) cycle();
        #2;
        do_reset();
        ph_idx = 0;
        set_lights(phase_val(0));
        repeat (SC + 2) cycle();
        run_phases(4);

        // watchdog: a change at count 30 is safe, holding one cycle longer faults
        hold_trial(MH - 1);
        check("wd_no_fault", fault, 1'b0);
        run_phases(2);
        hold_trial(MH);
        check("wd_fault", fault, 1'b1);
        check("wd_code", fault_code, 3'd4);
        repeat (4) cycle();
        do_clear();

        // two more fault/clear rounds
        force_conflict();
        repeat (4) cycle();
        do_clear();
        force_conflict();
        repeat (4) cycle();
        do_clear();
`ifdef TRAFFIC_MONITOR_FAULT_COUNT_EN
        check("count_three", fault_count, 8'd3);
        do_reset();
        check("count_reset", fault_count, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Downstream safety stage between Traffic_Light_Controller and the lamp drivers.
- Registers the four 3-bit light vectors (M1, M2, MT, S) and checks each cycle for illegal encodings, conflicting right-of-way, green-to-red without yellow, and stuck outputs.
- Passes clean patterns through. On any fault it latches a fault code and drives a fail-safe flash pattern until software clears it.

Parameters:
- STARTUP_CYCLES, 16, cycles of all-red after reset or fault clear before pass-through.
- FLASH_HALF, 8, cycles per half-period of the fail-safe blink.
- MAX_HOLD, 1024, cycles the input pattern may stay unchanged before a watchdog fault.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- light_M1_in  in  3  controller output, main road 1; encoding {R,Y,G} = bit2,bit1,bit0
- light_M2_in  in  3  controller output, main road 2
- light_MT_in  in  3  controller output, main turn
- light_S_in  in  3  controller output, side road
- fault_clr  in  1  single-cycle request to leave fault state
- light_M1  out  3  lamp drive, main road 1
- light_M2  out  3  lamp drive, main road 2
- light_MT  out  3  lamp drive, main turn
- light_S  out  3  lamp drive, side road
- fault  out  1  high while in FAULT_FLASH
- fault_code  out  3  latched cause: 0 none, 1 invalid encoding, 2 conflict, 3 skipped yellow, 4 watchdog

Behaviour:
- Stage 1 registers all four inputs (r_*). Checks are combinational on r_*. Stage 2 registers the outputs. Pass-through latency is 2 cycles.
- A faulting pattern never reaches the outputs: in the cycle the fault is detected, stage 2 loads the flash pattern instead.
- Reset (rst=0) sets:
  - state = STARTUP, counters 0.
  - All four lamp outputs = 3'b100 (red).
  - fault = 0, fault_code = 0, r_* = 3'b100.
- Valid encoding: exactly one bit set. 000, 011, 101, 110 and 111 are invalid.
- "Go" means green or yellow.
- Conflict:
  - S go while any of M1, M2 or MT is go.
  - MT go while M2 is go.
- Skipped yellow: a lane whose previous r_* was 001 now reads 100.
- Watchdog: counts cycles in PASS with r_* unchanged. Reset to 0 on any change. Fault when count reaches MAX_HOLD-1.
- Priority when several checks fire together: conflict(2) > invalid(1) > skipped yellow(3) > watchdog(4).
- STARTUP:
  - Outputs all red. Counter runs to STARTUP_CYCLES-1, then go to PASS.
  - Fault checks are disabled except conflict. A conflict here goes to FAULT_FLASH.
- PASS:
  - Outputs = r_* (one cycle later).
  - Any fault goes to FAULT_FLASH, latching fault_code and setting fault=1 in the same stage-2 update.
- FAULT_FLASH:
  - Blink phase starts ON at entry and toggles every FLASH_HALF cycles.
  - ON: M1, M2 and MT = 010 (yellow), S = 100. OFF: all 000.
  - fault_code holds its value; later faults do not overwrite it.
- fault_clr:
  - Honoured only in FAULT_FLASH, and only if the current r_* is fault-free (encoding and conflict checks).
  - When honoured: state goes to STARTUP, fault and fault_code go to 0, the watchdog counter is cleared.
  - Otherwise ignored, with no pending latch.
  - fault_clr is ignored outside FAULT_FLASH.
- Reset mid-operation: asynchronous. All state returns to reset values immediately, including from FAULT_FLASH.

Optional Feature:
- Macro: TRAFFIC_MONITOR_FAULT_COUNT_EN.
- Defined: adds output fault_count [7:0].
  - Increments on each entry to FAULT_FLASH and saturates at 255.
  - Cleared only by rst, not by fault_clr.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then clean cycle: rst=0 for 2 cycles, release, feed a legal sequence (M1/M2 green, S red, ...) → outputs 100 for 16 cycles, then inputs mirrored with 2-cycle latency; fault=0 throughout.
- Conflict: in PASS, drive light_S_in=001 with light_M1_in=001 → fault=1 and fault_code=2 two cycles later; the conflicting pattern never appears on the outputs; M1/M2/MT show 010 and S shows 100 for 8 cycles, then all 000 for 8 cycles.
- Invalid and skipped yellow:
  - light_MT_in=011 → fault_code=1.
  - After reset, light_M1_in goes 001→100 directly → fault_code=3.
- Watchdog: hold legal inputs constant in PASS for MAX_HOLD cycles (shrunk to 32 via the parameter) → fault_code=4 at count 31; a change at count 30 prevents the fault.
- Clear handling:
  - fault_clr while inputs are still conflicting → stays in fault.
  - Inputs fixed, then fault_clr → fault=0, fault_code=0, 16 cycles all-red, then pass-through.
  - rst asserted mid-flash → outputs 100 immediately.
- With TRAFFIC_MONITOR_FAULT_COUNT_EN: three fault/clear rounds → fault_count=3; fault_clr does not change it; rst sets it to 0.
